// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, aluop codes, mux encodings and main-FSM states shared by the MIPS controller.
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_B     = 2'b00;
    localparam logic [1:0] ALUB_4     = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;
endpackage

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS main control FSM; Moore outputs except memready-gated fetch writes
// and the op-gated illegal_op pulse in DECODE.
module mc_maindec
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               memready,
    input  logic               zero,
    output logic               pcwrite,
    output logic               branch,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [1:0]         aluop,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);
    state_t state_q, state_d;
    logic   unused_zero;

    assign unused_zero = zero;
    assign state       = STATE_W'(state_q);

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;

    always_comb begin
        state_d    = S_FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUB_B;
        pcsrc      = PC_ALURES;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = ALUB_4;
                irwrite = memready;
                pcwrite = memready;
                state_d = memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = ALUB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUB_IMM;
                state_d = op == OP_LW ? S_MEMRD : op == OP_SW ? S_MEMWR : S_FETCH;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = memready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = ALUB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: directed instruction sequences; per-cycle expected state/controls are queued
// when inputs are driven and popped for comparison once the outputs settle.
module tb_mc_maindec;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic       memready = 1'b0;
    logic       zero = 1'b0;
    logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [15:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] e_fetch_r, e_fetch_w, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [15:0] e_rtex, e_rtwb, e_beq, e_addiex, e_addiwb, e_jex;

    mc_maindec #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready), .zero(zero),
        .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: pcwrite branch iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc aluop illegal_op
    function automatic logic [15:0] mk(input logic pcw, br, io, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, pcs, aop, input logic ill);
        return {pcw, br, io, mw, irw, rd, m2r, rw, asa, asb, pcs, aop, ill};
    endfunction

    task automatic step(input string tag, input logic rst_v, input logic mr, input logic [5:0] o,
                        input logic [3:0] st, input logic [15:0] ctl);
        exp_t e;
        reset    = rst_v;
        memready = mr;
        op       = o;
        zero     = $urandom_range(0, 1);
        sb.push_back('{tag, st, ctl});
        #1;
        e = sb.pop_front();
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        checks++;
        assert ({pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, aluop, illegal_op} === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: got %04h expected %04h", e.tag,
                   {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                    alusrcb, pcsrc, aluop, illegal_op}, e.ctl);
        end
        @(negedge clk);
    endtask

    initial begin
        e_fetch_r    = mk(1,0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        e_fetch_w    = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        e_decode     = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        e_decode_ill = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        e_memadr     = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        e_memrd      = mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        e_memwb      = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        e_memwr      = mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        e_rtex       = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
        e_rtwb       = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        e_beq        = mk(0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        e_addiex     = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        e_addiwb     = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        e_jex        = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);
        @(negedge clk);
        step("rst_mr0", 1, 0, 6'h00, 0, e_fetch_w);
        step("rst_mr1", 1, 1, 6'h00, 0, e_fetch_r);
        // lw, memready tied high: 5 cycles
        step("lw_fetch",  0, 1, 6'b100011, 0, e_fetch_r);
        step("lw_decode", 0, 1, 6'b100011, 1, e_decode);
        step("lw_memadr", 0, 1, 6'b100011, 2, e_memadr);
        step("lw_memrd",  0, 1, 6'b111111, 3, e_memrd);
        step("lw_memwb",  0, 1, 6'b000000, 4, e_memwb);
        // lw with memory wait, then reset in MEMWB
        step("lw2_fetch_wait", 0, 0, 6'b100011, 0, e_fetch_w);
        step("lw2_fetch",  0, 1, 6'b100011, 0, e_fetch_r);
        step("lw2_decode", 0, 1, 6'b100011, 1, e_decode);
        step("lw2_memadr", 0, 1, 6'b100011, 2, e_memadr);
        step("lw2_memrd_wait", 0, 0, 6'b000100, 3, e_memrd);
        step("lw2_memrd",  0, 1, 6'b000100, 3, e_memrd);
        step("lw2_memwb",  0, 1, 6'b100011, 4, e_memwb);
        step("lw2_reset",  1, 0, 6'b100011, 0, e_fetch_w);
        step("post_rst_wait", 0, 0, 6'b000000, 0, e_fetch_w);
        // R-type: 4 cycles
        step("rt_fetch",  0, 1, 6'b000000, 0, e_fetch_r);
        step("rt_decode", 0, 1, 6'b000000, 1, e_decode);
        step("rt_ex",     0, 1, 6'b000000, 6, e_rtex);
        step("rt_wb",     0, 1, 6'b000000, 7, e_rtwb);
        // sw with three wait cycles in MEMWR
        step("sw_fetch",  0, 1, 6'b101011, 0, e_fetch_r);
        step("sw_decode", 0, 1, 6'b101011, 1, e_decode);
        step("sw_memadr", 0, 1, 6'b101011, 2, e_memadr);
        step("sw_memwr0", 0, 0, 6'b101011, 5, e_memwr);
        step("sw_memwr1", 0, 0, 6'b100011, 5, e_memwr);
        step("sw_memwr2", 0, 0, 6'b101011, 5, e_memwr);
        step("sw_memwr3", 0, 1, 6'b101011, 5, e_memwr);
        // beq then j: 3 cycles each
        step("beq_fetch",  0, 1, 6'b000100, 0, e_fetch_r);
        step("beq_decode", 0, 1, 6'b000100, 1, e_decode);
        step("beq_ex",     0, 1, 6'b000100, 8, e_beq);
        step("j_fetch",    0, 1, 6'b000010, 0, e_fetch_r);
        step("j_decode",   0, 1, 6'b000010, 1, e_decode);
        step("j_ex",       0, 1, 6'b000010, 11, e_jex);
        // addi: 4 cycles
        step("addi_fetch",  0, 1, 6'b001000, 0, e_fetch_r);
        step("addi_decode", 0, 1, 6'b001000, 1, e_decode);
        step("addi_ex",     0, 1, 6'b001000, 9, e_addiex);
        step("addi_wb",     0, 1, 6'b001000, 10, e_addiwb);
        // illegal opcode: 2 cycles, one-cycle pulse
        step("ill_fetch",  0, 1, 6'b111111, 0, e_fetch_r);
        step("ill_decode", 0, 1, 6'b111111, 1, e_decode_ill);
        step("ill_back",   0, 0, 6'b111111, 0, e_fetch_w);
        step("ill_fetch2", 0, 1, 6'b010001, 0, e_fetch_r);
        step("ill_decode2", 0, 1, 6'b010001, 1, e_decode_ill);
        step("end_fetch",  0, 0, 6'b000000, 0, e_fetch_w);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
